// File: rtl/cpu_bus_responder.sv
// Single-beat valid/ready memory responder backed by a word-addressed RAM.
// Each accepted request is answered after a fixed number of wait cycles.
module cpu_bus_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] txn_count
);

    localparam int unsigned Words     = 1 << DEPTH_LOG2;
    localparam logic [32:0] SpanBytes = 33'd4 << DEPTH_LOG2;
    localparam bit          NoWait    = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WaitInit  = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] txn_count_q, txn_count_d;

    logic [31:0] mem [Words];

    logic                  accept;
    logic                  go_resp;
    logic                  op_we;
    logic [31:0]           op_addr;
    logic [31:0]           op_wdata;
    logic [3:0]            op_wstrb;
    logic [31:0]           op_off;
    logic                  op_err;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic                  mem_we;

    // With no wait states the RAM access happens on the accepting edge, so the
    // operands come straight from the request bus instead of the latches.
    always_comb begin
        req_ready = rst_n && (state_q == StIdle);
        accept    = req_valid && req_ready;
        op_we     = (state_q == StIdle) ? req_we    : we_q;
        op_addr   = (state_q == StIdle) ? req_addr  : addr_q;
        op_wdata  = (state_q == StIdle) ? req_wdata : wdata_q;
        op_wstrb  = (state_q == StIdle) ? req_wstrb : wstrb_q;
        op_off    = op_addr - BASE_ADDR;
        op_err    = (op_addr[1:0] != 2'b00) || ({1'b0, op_off} >= SpanBytes);
        op_idx    = op_off[DEPTH_LOG2+1:2];
        go_resp   = rst_n && ((NoWait && (state_q == StIdle) && accept) ||
                              ((state_q == StWait) && (cnt_q == 4'd0)));
        mem_we    = go_resp && op_we && !op_err;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        txn_count_d = txn_count_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (NoWait) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = op_err;
            rsp_rdata_d = (op_err || op_we) ? 32'h0 : mem[op_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            txn_count_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            txn_count_q <= txn_count_d;
        end
    end

    // RAM has no reset; mem_we is already gated by rst_n through go_resp.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (op_wstrb[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_count_q;

endmodule
